pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sequences the startup and recovery of an EHXPLLL-based clock generator, such as the 100 MHz to 10 MHz CPU clock PLL.
- Pulses the PLL reset, waits for LOCK with a timeout and bounded retries, and requires LOCK to be stable before releasing the downstream system reset.
- On loss of lock it re-asserts the system reset and restarts the PLL.
- Runs on the board input clock, i.e. the PLL reference clock, never on a PLL output.

Parameters:
- RST_PULSE_CYCLES, 16: clkin cycles the PLL reset is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 100000: clkin cycles allowed in WAIT_LOCK before an attempt fails (>=2).
- MAX_RETRIES, 3: failed attempts allowed before FAULT (1..15).

Ports:
- clkin  input  1  board reference clock; sole clock.
- reset  input  1  asynchronous active-high reset.
- pll_locked  input  1  raw PLL LOCK; asynchronous to clkin.
- restart  input  1  synchronous single-cycle request to restart the sequence.
- pll_rst  output  1  drives PLL RST; active-high.
- sys_reset  output  1  active-high reset for logic clocked by the PLL output.
- ready  output  1  high only in RUN.
- fault  output  1  high only in FAULT.
- retry_cnt  output  4  failed attempts in the current sequence.
- loss_cnt  output  8  lock losses observed in RUN; saturates at 255.

Behaviour:
- All outputs are registered. There is no combinational path from input to output.
- Reset values: state=PLL_RST, cnt=0, pll_rst=1, sys_reset=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, sync flops=0.
- pll_locked passes through a 2-FF synchronizer to give lock_s. All decisions use lock_s only, which adds 2 cycles of latency.
- One shared counter cnt, width $clog2 of the largest parameter plus 1. It is cleared on every state transition.
- PLL_RST state:
  - pll_rst=1, sys_reset=1.
  - When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK state:
  - pll_rst=0, sys_reset=1.
  - If lock_s=1, go to STABLE.
  - Otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1, increment retry_cnt. If the new value equals MAX_RETRIES go to FAULT, else go to PLL_RST.
- STABLE state:
  - pll_rst=0, sys_reset=1.
  - If lock_s=0, go to WAIT_LOCK. The timeout restarts from 0; retry_cnt is unchanged.
  - If lock_s=1 and cnt==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN state:
  - sys_reset=0 and ready=1, both registered on entry.
  - retry_cnt is cleared on entry.
  - If lock_s=0, go to PLL_RST and increment loss_cnt (saturating). sys_reset=1 and ready=0 on the next edge.
- FAULT state:
  - pll_rst=1, sys_reset=1, fault=1.
  - Terminal until reset or restart.
- restart:
  - In any state, on the next edge: go to PLL_RST, retry_cnt=0, fault=0, cnt=0. loss_cnt is kept.
  - restart has priority over every other transition in the same cycle, including a lock loss in RUN; loss_cnt is not incremented in that case.
- Glitch handling:
  - A lock_s glitch of any length during STABLE restarts stable qualification.
  - A 1-cycle lock_s drop in RUN counts as a loss.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously).
- Invariant: sys_reset=0 implies pll_rst=0 and lock_s=1 for at least LOCK_STABLE_CYCLES cycles.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal lock: release reset, drive pll_locked=1 ten cycles after pll_rst falls.
  - pll_rst is high exactly 4 cycles.
  - sys_reset falls and ready rises exactly 2+8 cycles after pll_locked rises (±1 for the STABLE→RUN register).
  - retry_cnt=0, fault=0.
- Timeout and fault: hold pll_locked=0.
  - pll_rst pulses 4 cycles, then stays low 32 cycles; this repeats once.
  - retry_cnt goes 1 then 2, then fault=1 with pll_rst=1 and sys_reset=1 held indefinitely.
  - A restart pulse clears fault and retry_cnt, and pll_rst pulses again.
- Unstable lock: in STABLE, drop pll_locked for 1 cycle after 5 stable cycles.
  - Stays in WAIT_LOCK/STABLE with sys_reset=1.
  - Release happens only after a fresh 8 consecutive locked cycles.
- Loss in RUN: from RUN, drop pll_locked for 1 cycle.
  - 3 cycles later sys_reset=1, ready=0, pll_rst=1, loss_cnt=1.
  - With pll_locked restored, the sequencer returns to RUN.
- Priority and reset: in RUN, assert restart in the same cycle lock_s falls.
  - loss_cnt is unchanged and the state is PLL_RST.
  - Separately, assert reset asynchronously mid-WAIT_LOCK: pll_rst=1, sys_reset=1, and all counters are 0 before the next clkin edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Startup/recovery sequencer for an EHXPLLL clock generator: pulses PLL RST, qualifies LOCK,
// releases the downstream reset, and restarts on lock loss. Clocked by the PLL reference only.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int unsigned MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                     RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      sync;
    logic            lock_s;
    logic [3:0]      retry_next;

    assign lock_s = sync[1];

    always_comb begin
        retry_next = retry_cnt + 4'd1;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            sync      <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            sync <= {sync[0], pll_locked};
            // restart outranks every state transition, including a lock loss in RUN
            if (restart) begin
                state     <= PLL_RST;
                cnt       <= '0;
                pll_rst   <= 1'b1;
                sys_reset <= 1'b1;
                ready     <= 1'b0;
                fault     <= 1'b0;
                retry_cnt <= '0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == PULSE_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            retry_cnt <= retry_next;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            if (retry_next == RETRY_LIMIT) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end else begin
                                state <= PLL_RST;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state     <= RUN;
                            cnt       <= '0;
                            sys_reset <= 1'b0;
                            ready     <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state     <= PLL_RST;
                            cnt       <= '0;
                            pll_rst   <= 1'b1;
                            sys_reset <= 1'b1;
                            ready     <= 1'b0;
                            if (loss_cnt != 8'hFF) begin
                                loss_cnt <= loss_cnt + 8'd1;
                            end
                        end
                    end
                    FAULT: begin
                        cnt <= '0;
                    end
                    default: begin
                        state   <= PLL_RST;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
